// File: rtl/prv_trap_ctrl.sv
// Privileged trap controller: arbitrates exceptions, interrupts, xRET and WFI,
// drains the pipeline, then issues a single-cycle PC redirect with CSR strobes.
module prv_trap_ctrl #(
  parameter int NUM_INT       = 16,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int VECTORED_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        exc_req,
  input  logic [31:0]        exc_epc,
  input  logic [31:0]        exc_tval,
  input  logic [NUM_INT-1:0] int_pending,
  input  logic [NUM_INT-1:0] int_enable,
  input  logic               global_ie,
  input  logic               ret_req,
  input  logic               wfi_req,
  input  logic [31:0]        xtvec,
  input  logic [31:0]        xepc_r,
  input  logic               pipe_clear_ack,
  output logic               pipe_clear_req,
  output logic               insert_pc,
  output logic [31:0]        priv_pc,
  output logic               trap_commit,
  output logic               ret_commit,
  output logic [31:0]        trap_cause,
  output logic [31:0]        trap_epc,
  output logic [31:0]        trap_tval,
  output logic               sleeping,
  output logic               drain_timeout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] SLEEP  = 2'd3;

  localparam logic [9:0] TMO = 10'(DRAIN_TIMEOUT);

  // Exception causes, highest priority in the lowest nibble.
  localparam logic [63:0] EXC_ORDER = {4'd15, 4'd14, 4'd13, 4'd12, 4'd10, 4'd5, 4'd7, 4'd4,
                                       4'd6,  4'd11, 4'd9,  4'd8,  4'd0,  4'd2, 4'd1, 4'd3};

  logic [1:0]         state;
  logic [9:0]         cnt;
  logic               kind_ret;
  logic               tc_int;
  logic [4:0]         tc_cause;
  logic [NUM_INT-1:0] int_live, int_elig;
  logic [4:0]         exc_cause, int_cause;
  logic               ack_ok;
  logic [31:0]        base;

  assign int_live = int_pending & int_enable;
  assign int_elig = int_live & {NUM_INT{global_ie}};

  // An ack in the first DRAIN cycle predates our clear request, so it is not trusted.
  assign ack_ok = pipe_clear_ack && (cnt != '0);

  // Fixed-priority exception select: walk from lowest to highest priority, last hit wins.
  always_comb begin
    logic [3:0] idx;
    exc_cause = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = EXC_ORDER[i*4 +: 4];
      if (exc_req[idx]) exc_cause = {1'b0, idx};
    end
  end

  // Highest-index eligible interrupt wins.
  always_comb begin
    int_cause = '0;
    for (int i = 0; i < NUM_INT; i++)
      if (int_elig[i]) int_cause = 5'(i);
  end

  // Control FSM, latched trap info, drain counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      kind_ret      <= 1'b0;
      tc_int        <= 1'b0;
      tc_cause      <= '0;
      trap_epc      <= '0;
      trap_tval     <= '0;
      drain_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|exc_req) begin
            state     <= DRAIN;
            cnt       <= '0;
            kind_ret  <= 1'b0;
            tc_int    <= 1'b0;
            tc_cause  <= exc_cause;
            trap_epc  <= exc_epc;
            trap_tval <= exc_tval;
          end else if (|int_elig) begin
            state     <= DRAIN;
            cnt       <= '0;
            kind_ret  <= 1'b0;
            tc_int    <= 1'b1;
            tc_cause  <= int_cause;
            trap_epc  <= exc_epc;
            trap_tval <= '0;
          end else if (ret_req) begin
            state    <= DRAIN;
            cnt      <= '0;
            kind_ret <= 1'b1;
          end else if (wfi_req) begin
            state <= SLEEP;
          end
        end
        DRAIN: begin
          cnt <= cnt + 10'd1;
          if (ack_ok) begin
            state <= COMMIT;
          end else if (cnt == TMO) begin
            state         <= COMMIT;
            drain_timeout <= 1'b1;
          end
        end
        COMMIT: state <= IDLE;
        SLEEP:  if (|int_live) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pipe_clear_req = (state == DRAIN);
  assign insert_pc      = (state == COMMIT);
  assign trap_commit    = insert_pc & ~kind_ret;
  assign ret_commit     = insert_pc &  kind_ret;
  assign sleeping       = (state == SLEEP);
  assign trap_cause     = {tc_int, 26'd0, tc_cause};
  assign base           = {xtvec[31:2], 2'b00};

  // Redirect target, driven only during COMMIT.
  always_comb begin
    priv_pc = '0;
    if (insert_pc) begin
      if (kind_ret)
        priv_pc = xepc_r;
      else if ((VECTORED_EN != 0) && (xtvec[1:0] == 2'b01) && tc_int)
        priv_pc = base + {25'd0, tc_cause, 2'b00};
      else
        priv_pc = base;
    end
  end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed bench for prv_trap_ctrl with hand-computed expectations.
module tb_prv_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] exc_req;
  logic [31:0] exc_epc, exc_tval;
  logic [15:0] int_pending, int_enable;
  logic        global_ie, ret_req, wfi_req;
  logic [31:0] xtvec, xepc_r;
  logic        pipe_clear_ack;
  logic        pipe_clear_req, insert_pc, trap_commit, ret_commit, sleeping, drain_timeout;
  logic [31:0] priv_pc, trap_cause, trap_epc, trap_tval;

  int n_chk = 0;
  int n_err = 0;
  int lat;
  logic seen;

  always #5 clk = ~clk;

  prv_trap_ctrl dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .int_pending(int_pending), .int_enable(int_enable), .global_ie(global_ie),
    .ret_req(ret_req), .wfi_req(wfi_req), .xtvec(xtvec), .xepc_r(xepc_r),
    .pipe_clear_ack(pipe_clear_ack), .pipe_clear_req(pipe_clear_req), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .trap_commit(trap_commit), .ret_commit(ret_commit),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .sleeping(sleeping), .drain_timeout(drain_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    exc_req = '0; int_pending = '0; ret_req = 1'b0; wfi_req = 1'b0;
  endtask

  // Request already applied in cycle 0; returns cycles until insert_pc (bounded).
  task automatic run_req(input int ack_at, output int n);
    pipe_clear_ack = (ack_at == 0);
    tick;
    n = 1;
    clr_req;
    if (n == ack_at) pipe_clear_ack = 1'b1;
    while (!insert_pc && n < 200) begin
      tick;
      n++;
      if (n == ack_at) pipe_clear_ack = 1'b1;
    end
  endtask

  logic [15:0] ev_mask [6] = '{16'h0101, 16'h0420, 16'h1400, 16'h0240, 16'h00A0, 16'h0310};
  logic [31:0] ev_cause[6] = '{32'd0, 32'd5, 32'd10, 32'd9, 32'd7, 32'd8};

  initial begin
    rst = 1'b1;
    clr_req;
    int_enable = '0; global_ie = 1'b0; exc_epc = '0; exc_tval = '0;
    xtvec = '0; xepc_r = '0; pipe_clear_ack = 1'b0;
    tick; tick;
    rst = 1'b0;

    // Reset state
    chk("rst_pcr", {31'd0, pipe_clear_req}, 32'd0);
    chk("rst_ins", {31'd0, insert_pc}, 32'd0);
    chk("rst_slp", {31'd0, sleeping}, 32'd0);
    chk("rst_dt", {31'd0, drain_timeout}, 32'd0);
    chk("rst_cause", trap_cause, 32'd0);
    chk("rst_pc", priv_pc, 32'd0);

    // Vectored interrupt 7, ack held high
    xtvec = 32'h8000_0001; int_pending = 16'h0080; int_enable = 16'h0080; global_ie = 1'b1;
    exc_epc = 32'h100; exc_tval = 32'hDEAD; pipe_clear_ack = 1'b1;
    chk("c0_pcr", {31'd0, pipe_clear_req}, 32'd0);
    tick;
    chk("c1_pcr", {31'd0, pipe_clear_req}, 32'd1);
    clr_req;
    tick;
    chk("c2_pcr", {31'd0, pipe_clear_req}, 32'd1);
    chk("c2_ins", {31'd0, insert_pc}, 32'd0);
    tick;
    chk("c3_ins", {31'd0, insert_pc}, 32'd1);
    chk("c3_pc", priv_pc, 32'h8000_001C);
    chk("c3_cause", trap_cause, 32'h8000_0007);
    chk("c3_tc", {31'd0, trap_commit}, 32'd1);
    chk("c3_rc", {31'd0, ret_commit}, 32'd0);
    chk("c3_pcr", {31'd0, pipe_clear_req}, 32'd0);
    chk("c3_epc", trap_epc, 32'h100);
    chk("c3_tval", trap_tval, 32'd0);
    tick;
    chk("c4_ins", {31'd0, insert_pc}, 32'd0);

    // Highest eligible interrupt index wins; disabled 15 ignored
    int_pending = 16'h8204; int_enable = 16'h0204; exc_epc = 32'h300;
    run_req(0, lat);
    chk("ip_lat", 32'(lat), 32'd3);
    chk("ip_cause", trap_cause, 32'h8000_0009);
    chk("ip_pc", priv_pc, 32'h8000_0024);
    chk("ip_epc", trap_epc, 32'h300);
    tick;

    // Vector offset wraps modulo 2^32
    xtvec = 32'hFFFF_FFFD; int_pending = 16'h8000; int_enable = 16'h8000;
    run_req(0, lat);
    chk("wrap_pc", priv_pc, 32'h0000_0038);
    chk("wrap_cause", trap_cause, 32'h8000_000F);
    tick;

    // Exception beats interrupt; cause 3 beats 2; exceptions use base even in vectored mode
    xtvec = 32'h8000_0001; exc_req = 16'h000C; int_pending = 16'h0020; int_enable = 16'h0020;
    exc_epc = 32'h200; exc_tval = 32'hBAD;
    run_req(0, lat);
    chk("ex_lat", 32'(lat), 32'd3);
    chk("ex_cause", trap_cause, 32'd3);
    chk("ex_pc", priv_pc, 32'h8000_0000);
    chk("ex_tval", trap_tval, 32'hBAD);
    chk("ex_epc", trap_epc, 32'h200);
    tick;

    // Exception priority vectors
    for (int i = 0; i < 6; i++) begin
      exc_req = ev_mask[i]; exc_tval = 32'h1000 + 32'(i);
      run_req(0, lat);
      chk("pri_cause", trap_cause, ev_cause[i]);
      chk("pri_tval", trap_tval, 32'h1000 + 32'(i));
      tick;
    end

    // xRET with ack delayed 5 cycles; trap CSRs untouched
    ret_req = 1'b1; xepc_r = 32'h0000_1234;
    run_req(7, lat);
    chk("ret_lat", 32'(lat), 32'd8);
    chk("ret_rc", {31'd0, ret_commit}, 32'd1);
    chk("ret_tc", {31'd0, trap_commit}, 32'd0);
    chk("ret_pc", priv_pc, 32'h0000_1234);
    chk("ret_cause", trap_cause, 32'd8);
    chk("ret_tval", trap_tval, 32'h1005);
    tick;

    // Ack in the timeout cycle wins
    xtvec = 32'h0000_4001; exc_req = 16'h0002;
    run_req(65, lat);
    chk("tie_lat", 32'(lat), 32'd66);
    chk("tie_dt", {31'd0, drain_timeout}, 32'd0);
    chk("tie_pc", priv_pc, 32'h0000_4000);
    tick;

    // Ack one cycle before timeout
    exc_req = 16'h0002;
    run_req(64, lat);
    chk("pre_lat", 32'(lat), 32'd65);
    chk("pre_dt", {31'd0, drain_timeout}, 32'd0);
    tick;

    // Ack never comes
    exc_req = 16'h0002;
    run_req(1000, lat);
    chk("tmo_lat", 32'(lat), 32'd66);
    chk("tmo_dt", {31'd0, drain_timeout}, 32'd1);
    chk("tmo_cause", trap_cause, 32'd1);
    tick;
    exc_req = 16'h0001;
    run_req(0, lat);
    chk("tmo_sticky_lat", 32'(lat), 32'd3);
    chk("tmo_sticky", {31'd0, drain_timeout}, 32'd1);
    tick;

    // WFI wakes on pending&enable even with global_ie=0, no trap
    global_ie = 1'b0; int_enable = 16'h0008; wfi_req = 1'b1;
    tick;
    chk("wfi_slp", {31'd0, sleeping}, 32'd1);
    chk("wfi_pcr", {31'd0, pipe_clear_req}, 32'd0);
    wfi_req = 1'b0;
    tick;
    chk("wfi_hold", {31'd0, sleeping}, 32'd1);
    int_pending = 16'h0008;
    tick;
    chk("wfi_wake", {31'd0, sleeping}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | insert_pc | pipe_clear_req;
    end
    chk("wfi_notrap", {31'd0, seen}, 32'd0);
    clr_req;
    tick;

    // WFI then eligible interrupt: wake, then trap cause 3
    global_ie = 1'b1; wfi_req = 1'b1;
    tick;
    chk("wfi2_slp", {31'd0, sleeping}, 32'd1);
    wfi_req = 1'b0; xtvec = 32'h0000_2000; int_pending = 16'h0008;
    tick;
    chk("wfi2_wake", {31'd0, sleeping}, 32'd0);
    run_req(0, lat);
    chk("wfi2_lat", 32'(lat), 32'd3);
    chk("wfi2_cause", trap_cause, 32'h8000_0003);
    chk("wfi2_pc", priv_pc, 32'h0000_2000);
    tick;

    // Reset in DRAIN cycle 2
    exc_req = 16'h0004; exc_epc = 32'h777; pipe_clear_ack = 1'b0;
    tick;
    clr_req;
    tick;
    chk("rd_pcr_pre", {31'd0, pipe_clear_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rd_pcr", {31'd0, pipe_clear_req}, 32'd0);
    chk("rd_ins", {31'd0, insert_pc}, 32'd0);
    chk("rd_cause", trap_cause, 32'd0);
    chk("rd_epc", trap_epc, 32'd0);
    chk("rd_tval", trap_tval, 32'd0);
    chk("rd_dt", {31'd0, drain_timeout}, 32'd0);
    chk("rd_pc", priv_pc, 32'd0);
    pipe_clear_ack = 1'b1;
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen = seen | insert_pc;
    end
    chk("rd_noins", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/prv_trap_ctrl.md
PRV_TRAP_CTRL -- requirements
Module: prv_trap_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 16, the number of interrupt lines (range 1..32).
REQ-002 SHALL have parameter DRAIN_TIMEOUT, default 64, the maximum number of cycles to wait for pipe_clear_ack (range 2..1023).
REQ-003 SHALL have parameter VECTORED_EN, default 1, which enables the xtvec vectored mode.
REQ-004 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  asynchronous reset, active-high.
REQ-006 exc_req  in  16  level exception requests, one per RISC-V cause index 0..15.
REQ-007 exc_epc, exc_tval  in  32  faulting PC and bad address/instruction, valid while any exc_req bit is set.
REQ-008 int_pending, int_enable  in  NUM_INT  interrupt pending and enable bits, one per cause index.
REQ-009 global_ie  in  1  global interrupt enable.
REQ-010 ret_req, wfi_req  in  1  xRET and WFI retirement requests (levels).
REQ-011 xtvec, xepc_r  in  32  trap vector CSR and return EPC CSR.
REQ-012 pipe_clear_ack  in  1  the pipeline is drained and holds the request.
REQ-013 pipe_clear_req  out  1  request to flush and stall the pipeline.
REQ-014 insert_pc  out  1  one-cycle redirect strobe.
REQ-015 priv_pc  out  32  redirect target, valid while insert_pc is high.
REQ-016 trap_commit, ret_commit  out  1  one-cycle CSR update strobes.
REQ-017 trap_cause  out  32  mcause value: bit31 is the interrupt flag, bits[4:0] are the cause.
REQ-018 trap_epc, trap_tval  out  32  values to write to xepc and xtval.
REQ-019 sleeping  out  1  high while in WFI.
REQ-020 drain_timeout  out  1  sticky error flag, cleared only by reset.

Function
REQ-021 The FSM SHALL have the states IDLE, DRAIN, COMMIT and SLEEP.
REQ-022 Arbitration in IDLE SHALL use this priority: exception > interrupt > ret > wfi.
REQ-023 Exception priority SHALL be causes 3,1,2,0,8,9,11,6,4,7,5, then any remaining bits in ascending order.
REQ-024 An interrupt SHALL be eligible only if int_pending & int_enable & global_ie; among eligible interrupts the highest index wins.
REQ-025 When IDLE sees a request in cycle N, the block SHALL latch the kind, cause, epc and tval at edge N, enter DRAIN, and assert pipe_clear_req from cycle N+1.
REQ-026 For an interrupt, trap_epc SHALL be exc_epc as sampled (the pipeline supplies the next PC on exc_epc), and trap_tval SHALL be 0.
REQ-027 In DRAIN, request inputs SHALL be ignored and the latched values held; pipe_clear_req SHALL stay high until the cycle in which COMMIT is entered.
REQ-028 When pipe_clear_ack is high in DRAIN, the next cycle SHALL be COMMIT.
REQ-029 COMMIT SHALL last exactly one cycle, with insert_pc=1, pipe_clear_req=0, and either trap_commit or ret_commit equal to 1; the FSM then returns to IDLE.
REQ-030 Trap target: base = {xtvec[31:2],2'b00}.
REQ-031 If VECTORED_EN=1, xtvec[1:0]=01 and the trap is an interrupt, priv_pc SHALL be base + 4*cause, computed modulo 2^32.
REQ-032 In all other trap cases priv_pc SHALL be base.
REQ-033 For a return, priv_pc SHALL be xepc_r sampled in COMMIT; trap_cause, trap_epc and trap_tval SHALL be unchanged.
REQ-034 On wfi_req in IDLE (no higher-priority request), the FSM SHALL enter SLEEP, with sleeping=1 and no pipe_clear_req.
REQ-035 SLEEP SHALL exit to IDLE in the cycle after any (int_pending & int_enable) bit is set, regardless of global_ie; any trap is then taken by normal arbitration.
REQ-036 A DRAIN timeout counter SHALL start at 0 on entry and increment each DRAIN cycle.
REQ-037 If the counter reaches DRAIN_TIMEOUT without an ack, the block SHALL set drain_timeout and proceed to COMMIT anyway.
REQ-038 If ack and timeout occur in the same cycle, ack wins and drain_timeout is not set.
REQ-039 Latency from request to insert_pc SHALL be 3 cycles when the ack is immediate, and DRAIN_TIMEOUT+2 maximum.
REQ-040 Requests present in the COMMIT cycle SHALL be ignored; they are re-sampled in IDLE on the following cycle.

Reset
REQ-041 Asserting RST SHALL immediately set the state to IDLE, clear all outputs and registers to 0 (including drain_timeout), and clear the counter, even mid-DRAIN or mid-SLEEP.
REQ-042 After RST deasserts, the first request SHALL be sampled at the first rising edge of CLK.

Verification
REQ-043 xtvec=0x8000_0001 and int 7 eligible, ack held high -> pipe_clear_req in cycle 1, priv_pc=0x8000_001C, trap_cause=0x8000_0007 and insert_pc in cycle 3.
REQ-044 exc_req bits 2 and 3 set together with an int eligible -> cause 3 wins, priv_pc=0x8000_0000, trap_tval=exc_tval, trap_cause bit31=0.
REQ-045 ret_req with xepc_r=0x0000_1234 and ack delayed 5 cycles -> ret_commit, priv_pc=0x1234, insert_pc 8 cycles after the request.
REQ-046 Ack never asserted, DRAIN_TIMEOUT=64 -> drain_timeout=1 and insert_pc 66 cycles after the request; the flag stays set until RST.
REQ-047 wfi_req, then int 3 pending and enabled with global_ie=0 -> sleeping falls the next cycle with no trap; repeating with global_ie=1 -> trap taken with cause 3.
REQ-048 RST asserted in DRAIN cycle 2 -> all outputs are 0 in the same cycle, and no insert_pc occurs.
